// File: rtl/fft_frame_packer.sv
// fft_frame_packer: pops FIFO samples into 2^FRAME_LW-point frames on a registered stream with sop/eop/index.
// Optional FFT_FRAME_GAP_EN inserts GAP_CYC idle cycles between continuous frames.
module fft_frame_packer #(
  parameter int DATA_W   = 32,
  parameter int FRAME_LW = 10,
  parameter int IDX_W    = 8,
  parameter int GAP_CYC  = 4
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_vld,
  output logic              fifo_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sop,
  output logic              m_eop,
  output logic [IDX_W-1:0]  m_idx,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  if (FRAME_LW < 3 || FRAME_LW > 16 || GAP_CYC < 1 || GAP_CYC > 255) begin : g_bad_param
    $error("fft_frame_packer: parameter out of range");
  end
  logic [1:0] state, nxt;
  logic [FRAME_LW-1:0] pcnt;
  logic cont_q, stop_q, pop, last, more;
  assign fifo_en = (state == RUN) & (~m_valid | m_ready);
  assign pop = fifo_en & fifo_vld;
  assign last = &pcnt;
  assign more = cont_q & ~stop_q;
  assign busy = (state != IDLE) | m_valid;
`ifdef FFT_FRAME_GAP_EN
  localparam logic [1:0] GAP = 2'd2;
  logic [7:0] gcnt;
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) gcnt <= '0;
    else gcnt <= (state == GAP) ? gcnt + 8'd1 : 8'd0;
  always_comb begin
    nxt = state;
    if (state == IDLE && start) nxt = RUN;
    else if (state == RUN && pop && last) nxt = more ? GAP : IDLE;
    else if (state == GAP && gcnt == 8'(GAP_CYC - 1)) nxt = stop_q ? IDLE : RUN;
  end
`else
  always_comb begin
    nxt = state;
    if (state == IDLE && start) nxt = RUN;
    else if (state == RUN && pop && last) nxt = more ? RUN : IDLE;
  end
`endif
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      m_idx   <= '0;
    end else begin
      state  <= nxt;
      pcnt   <= (state == IDLE) ? '0 : pcnt + FRAME_LW'(pop);
      stop_q <= (nxt == IDLE) ? 1'b0 : stop_q | (stop & (state != IDLE));
      if (state == IDLE && start) cont_q <= cont;
      // a pop in the same cycle as an accept replaces the beat without a bubble
      if (pop) begin
        m_data  <= fifo_data;
        m_valid <= 1'b1;
        m_sop   <= (pcnt == '0);
        m_eop   <= last;
      end else if (m_ready) m_valid <= 1'b0;
      if (m_valid & m_ready & m_eop) m_idx <= m_idx + IDX_W'(1);
    end
endmodule
